// File: rtl/vga_layer_mixer.sv
// vga_layer_mixer: two-stage priority compositor of colour-keyed overlay layers over a background, with frame-boundary enable shadowing
module vga_layer_mixer #(
  parameter int NUM_LAYERS = 4,
  parameter int COLOR_W = 12,
  parameter int APPLY_LINE = 480,
  localparam int CW = COLOR_W / 3,
  localparam int HW = $clog2(NUM_LAYERS + 1)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          pix_en,
  input  logic [9:0]                    h_cnt,
  input  logic [9:0]                    v_cnt,
  input  logic                          valid_in,
  input  logic                          hsync_in,
  input  logic                          vsync_in,
  input  logic [NUM_LAYERS-1:0]         layer_valid,
  input  logic [NUM_LAYERS*COLOR_W-1:0] layer_pixel,
  input  logic [COLOR_W-1:0]            bg_pixel,
  input  logic [COLOR_W-1:0]            key_color,
  input  logic                          key_en,
  input  logic [NUM_LAYERS-1:0]         layer_en_wdata,
  input  logic                          layer_en_we,
  output logic                          hsync,
  output logic                          vsync,
  output logic [CW-1:0]                 vgaRed,
  output logic [CW-1:0]                 vgaGreen,
  output logic [CW-1:0]                 vgaBlue,
  output logic [NUM_LAYERS-1:0]         layer_en,
  output logic [HW-1:0]                 hit_layer
);
  logic [NUM_LAYERS-1:0] pending;
  logic pend_flag;
  logic apply;
  logic [NUM_LAYERS-1:0] opaque;
  logic [NUM_LAYERS-1:0] opaque1;
  logic [NUM_LAYERS*COLOR_W-1:0] px1;
  logic [COLOR_W-1:0] bg1;
  logic v1, hs1, vs1;
  logic [COLOR_W-1:0] sel_color;
  logic [HW-1:0] sel_hit;
  logic [COLOR_W-1:0] color;
  assign apply = pix_en && pend_flag && h_cnt == '0 && v_cnt == 10'(APPLY_LINE);
  always_ff @(posedge clk) begin
    if (rst) begin
      layer_en <= '1;
      pending <= '1;
      pend_flag <= 1'b0;
    end else if (apply) begin
      layer_en <= layer_en_we ? layer_en_wdata : pending;
      pending <= layer_en_we ? layer_en_wdata : pending;
      pend_flag <= 1'b0;
    end else if (layer_en_we) begin
      pending <= layer_en_wdata;
      pend_flag <= 1'b1;
    end
  end
  always_comb begin
    opaque = '0;
    for (int i = 0; i < NUM_LAYERS; i++)
      opaque[i] = layer_valid[i] & layer_en[i] & ~(key_en & (layer_pixel[i*COLOR_W +: COLOR_W] == key_color));
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      v1 <= 1'b0;
      hs1 <= 1'b1;
      vs1 <= 1'b1;
      opaque1 <= '0;
      px1 <= '0;
      bg1 <= '0;
    end else if (pix_en) begin
      v1 <= valid_in;
      hs1 <= hsync_in;
      vs1 <= vsync_in;
      opaque1 <= opaque;
      px1 <= layer_pixel;
      bg1 <= bg_pixel;
    end
  end
  always_comb begin
    sel_color = bg1;
    sel_hit = HW'(NUM_LAYERS);
    for (int i = NUM_LAYERS - 1; i >= 0; i--)
      if (opaque1[i]) begin
        sel_color = px1[i*COLOR_W +: COLOR_W];
        sel_hit = HW'(i);
      end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      color <= '0;
      hit_layer <= HW'(NUM_LAYERS);
      hsync <= 1'b1;
      vsync <= 1'b1;
    end else if (pix_en) begin
      color <= v1 ? sel_color : '0;
      hit_layer <= v1 ? sel_hit : HW'(NUM_LAYERS);
      hsync <= hs1;
      vsync <= vs1;
    end
  end
  assign vgaRed = color[COLOR_W-1 -: CW];
  assign vgaGreen = color[2*CW-1 -: CW];
  assign vgaBlue = color[CW-1:0];
endmodule

// File: tb/tb_vga_layer_mixer.sv
// tb_vga_layer_mixer: directed self-checking bench for vga_layer_mixer
module tb_vga_layer_mixer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic pix_en = 1'b1;
  logic [9:0] h_cnt = 10'd5;
  logic [9:0] v_cnt = 10'd100;
  logic valid_in = 1'b1;
  logic hsync_in = 1'b1;
  logic vsync_in = 1'b1;
  logic [3:0] layer_valid = 4'hF;
  logic [47:0] layer_pixel = {12'hFFF, 12'h00F, 12'h0F0, 12'hF00};
  logic [11:0] bg_pixel = 12'h444;
  logic [11:0] key_color = 12'hF0F;
  logic key_en = 1'b0;
  logic [3:0] layer_en_wdata = 4'hF;
  logic layer_en_we = 1'b0;
  logic hsync, vsync;
  logic [3:0] vgaRed, vgaGreen, vgaBlue;
  logic [3:0] layer_en;
  logic [2:0] hit_layer;
  logic [11:0] rgb;
  int tests = 0;
  int fails = 0;
  assign rgb = {vgaRed, vgaGreen, vgaBlue};
  always #5 clk = ~clk;
  vga_layer_mixer dut (
    .clk(clk), .rst(rst), .pix_en(pix_en), .h_cnt(h_cnt), .v_cnt(v_cnt),
    .valid_in(valid_in), .hsync_in(hsync_in), .vsync_in(vsync_in),
    .layer_valid(layer_valid), .layer_pixel(layer_pixel), .bg_pixel(bg_pixel),
    .key_color(key_color), .key_en(key_en), .layer_en_wdata(layer_en_wdata),
    .layer_en_we(layer_en_we), .hsync(hsync), .vsync(vsync), .vgaRed(vgaRed),
    .vgaGreen(vgaGreen), .vgaBlue(vgaBlue), .layer_en(layer_en), .hit_layer(hit_layer)
  );
  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic test_reset;
    rst = 1'b1;
    step(2);
    rst = 1'b0;
    tests++; if (rgb !== 12'h000) begin fails++; $display("FAIL reset_rgb got %h want 000", rgb); end
    tests++; if (hit_layer !== 3'd4) begin fails++; $display("FAIL reset_hit got %0d want 4", hit_layer); end
    tests++; if ({hsync, vsync} !== 2'b11) begin fails++; $display("FAIL reset_sync got %b want 11", {hsync, vsync}); end
    tests++; if (layer_en !== 4'hF) begin fails++; $display("FAIL reset_layer_en got %b want 1111", layer_en); end
  endtask
  task automatic test_priority;
    layer_valid = 4'hF;
    step(2);
    tests++; if (rgb !== 12'hF00 || hit_layer !== 3'd0) begin fails++; $display("FAIL prio_l0 got %h/%0d want f00/0", rgb, hit_layer); end
    layer_valid = 4'b1110;
    step(2);
    tests++; if (rgb !== 12'h0F0 || hit_layer !== 3'd1) begin fails++; $display("FAIL prio_l1 got %h/%0d want 0f0/1", rgb, hit_layer); end
    layer_valid = 4'b1000;
    step(2);
    tests++; if (rgb !== 12'hFFF || hit_layer !== 3'd3) begin fails++; $display("FAIL prio_l3 got %h/%0d want fff/3", rgb, hit_layer); end
    layer_valid = 4'b0000;
    step(2);
    tests++; if (rgb !== 12'h444 || hit_layer !== 3'd4) begin fails++; $display("FAIL prio_bg got %h/%0d want 444/4", rgb, hit_layer); end
  endtask
  task automatic test_keying;
    key_en = 1'b1;
    layer_pixel = {12'hFFF, 12'h00F, 12'h123, 12'hF0F};
    layer_valid = 4'b0011;
    step(2);
    tests++; if (rgb !== 12'h123 || hit_layer !== 3'd1) begin fails++; $display("FAIL key_skip got %h/%0d want 123/1", rgb, hit_layer); end
    layer_valid = 4'b0001;
    step(2);
    tests++; if (rgb !== 12'h444 || hit_layer !== 3'd4) begin fails++; $display("FAIL key_bg got %h/%0d want 444/4", rgb, hit_layer); end
    bg_pixel = 12'hF0F;
    step(2);
    tests++; if (rgb !== 12'hF0F || hit_layer !== 3'd4) begin fails++; $display("FAIL key_bg_unkeyed got %h/%0d want f0f/4", rgb, hit_layer); end
    key_en = 1'b0;
    step(2);
    tests++; if (rgb !== 12'hF0F || hit_layer !== 3'd0) begin fails++; $display("FAIL key_off got %h/%0d want f0f/0", rgb, hit_layer); end
    bg_pixel = 12'h444;
    layer_pixel = {12'hFFF, 12'h00F, 12'h0F0, 12'hF00};
  endtask
  task automatic test_blanking;
    layer_valid = 4'hF;
    valid_in = 1'b0;
    step(2);
    tests++; if (rgb !== 12'h000 || hit_layer !== 3'd4) begin fails++; $display("FAIL blank got %h/%0d want 000/4", rgb, hit_layer); end
    valid_in = 1'b1;
    step(2);
    tests++; if (rgb !== 12'hF00) begin fails++; $display("FAIL unblank got %h want f00", rgb); end
  endtask
  task automatic test_sync_align;
    vsync_in = 1'b0;
    step(1);
    tests++; if (vsync !== 1'b1) begin fails++; $display("FAIL vs_t1 got %b want 1", vsync); end
    step(1);
    tests++; if (vsync !== 1'b0) begin fails++; $display("FAIL vs_t2 got %b want 0", vsync); end
    vsync_in = 1'b1;
    step(1);
    tests++; if (vsync !== 1'b0) begin fails++; $display("FAIL vs_t3 got %b want 0", vsync); end
    step(1);
    tests++; if (vsync !== 1'b1) begin fails++; $display("FAIL vs_t4 got %b want 1", vsync); end
    hsync_in = 1'b0;
    layer_valid = 4'b1110;
    step(1);
    tests++; if (hsync !== 1'b1 || rgb !== 12'hF00) begin fails++; $display("FAIL hs_align1 got %b/%h want 1/f00", hsync, rgb); end
    hsync_in = 1'b1;
    step(1);
    tests++; if (hsync !== 1'b0 || rgb !== 12'h0F0) begin fails++; $display("FAIL hs_align2 got %b/%h want 0/0f0", hsync, rgb); end
    layer_valid = 4'hF;
    step(2);
  endtask
  task automatic test_shadow_enable;
    v_cnt = 10'd100;
    h_cnt = 10'd5;
    layer_en_wdata = 4'b1110;
    layer_en_we = 1'b1;
    step(1);
    layer_en_we = 1'b0;
    tests++; if (layer_en !== 4'hF) begin fails++; $display("FAIL shadow_hold got %b want 1111", layer_en); end
    h_cnt = 10'd0;
    step(3);
    tests++; if (layer_en !== 4'hF) begin fails++; $display("FAIL shadow_wrong_line got %b want 1111", layer_en); end
    v_cnt = 10'd480;
    h_cnt = 10'd3;
    step(1);
    tests++; if (layer_en !== 4'hF) begin fails++; $display("FAIL shadow_wrong_col got %b want 1111", layer_en); end
    h_cnt = 10'd0;
    step(1);
    tests++; if (layer_en !== 4'b1110) begin fails++; $display("FAIL shadow_apply got %b want 1110", layer_en); end
    h_cnt = 10'd1;
    step(1);
    tests++; if (rgb !== 12'hF00) begin fails++; $display("FAIL shadow_lat1 got %h want f00", rgb); end
    step(1);
    tests++; if (rgb !== 12'h0F0 || hit_layer !== 3'd1) begin fails++; $display("FAIL shadow_lat2 got %h/%0d want 0f0/1", rgb, hit_layer); end
  endtask
  task automatic test_apply_write;
    v_cnt = 10'd100;
    h_cnt = 10'd5;
    layer_en_wdata = 4'b0101;
    layer_en_we = 1'b1;
    step(1);
    v_cnt = 10'd480;
    h_cnt = 10'd0;
    layer_en_wdata = 4'b0011;
    step(1);
    layer_en_we = 1'b0;
    tests++; if (layer_en !== 4'b0011) begin fails++; $display("FAIL apply_write got %b want 0011", layer_en); end
    step(1);
    tests++; if (layer_en !== 4'b0011) begin fails++; $display("FAIL apply_write_hold got %b want 0011", layer_en); end
    h_cnt = 10'd5;
    v_cnt = 10'd100;
  endtask
  task automatic test_stall;
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    layer_valid = 4'hF;
    step(2);
    tests++; if (rgb !== 12'hF00) begin fails++; $display("FAIL stall_pre got %h want f00", rgb); end
    pix_en = 1'b0;
    layer_valid = 4'b1110;
    hsync_in = 1'b0;
    layer_en_wdata = 4'b1100;
    layer_en_we = 1'b1;
    step(1);
    layer_en_we = 1'b0;
    for (int i = 0; i < 9; i++) begin
      step(1);
      tests++; if (rgb !== 12'hF00 || hit_layer !== 3'd0 || hsync !== 1'b1) begin fails++; $display("FAIL stall_freeze%0d got %h/%0d/%b want f00/0/1", i, rgb, hit_layer, hsync); end
    end
    tests++; if (layer_en !== 4'hF) begin fails++; $display("FAIL stall_en got %b want 1111", layer_en); end
    pix_en = 1'b1;
    step(2);
    tests++; if (rgb !== 12'h0F0 || hsync !== 1'b0) begin fails++; $display("FAIL stall_resume got %h/%b want 0f0/0", rgb, hsync); end
  endtask
  task automatic test_reset_mid;
    pix_en = 1'b0;
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    tests++; if (rgb !== 12'h000 || hit_layer !== 3'd4) begin fails++; $display("FAIL rstmid_out got %h/%0d want 000/4", rgb, hit_layer); end
    tests++; if ({hsync, vsync} !== 2'b11 || layer_en !== 4'hF) begin fails++; $display("FAIL rstmid_state got %b/%b want 11/1111", {hsync, vsync}, layer_en); end
    pix_en = 1'b1;
    step(1);
    tests++; if (hsync !== 1'b1) begin fails++; $display("FAIL rstmid_pipe got %b want 1", hsync); end
    step(1);
    tests++; if (hsync !== 1'b0) begin fails++; $display("FAIL rstmid_pipe2 got %b want 0", hsync); end
    hsync_in = 1'b1;
    v_cnt = 10'd480;
    h_cnt = 10'd0;
    step(1);
    tests++; if (layer_en !== 4'hF) begin fails++; $display("FAIL rstmid_discard got %b want 1111", layer_en); end
  endtask
  initial begin
    test_reset();
    test_priority();
    test_keying();
    test_blanking();
    test_sync_align();
    test_shadow_enable();
    test_apply_write();
    test_stall();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
